div_arbiter: RTL

Shares a single `div_unsigned` instance between `NUM_REQ` pipeline stages, for example the gaussian_blur normaliser and the hough_transform vote scaling. Requesters use a valid/ready handshake. A round-robin arbiter grants one of them, and the block sequences the divider's single-pulse `valid_in`/`valid_out` protocol. The quotient is returned to the granted requester with its ID. Trivial operands are resolved without the divider: zero divisor, zero dividend, or dividend < divisor.

---
 rtl/div_arbiter_pkg.sv | 33 +++
 rtl/div_unsigned.sv | 79 +++++++
 rtl/div_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/div_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the divider arbiter.
package div_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  localparam int unsigned RR_MAX    = 32;
  localparam int unsigned RR_IDX_W  = 5;
  localparam int unsigned RR_CAND_W = RR_IDX_W + 1;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping modulo num_req.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   valid,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int unsigned         num_req);
    rr_pick_t             r;
    logic [RR_CAND_W-1:0] cand;
    r = '0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      cand = {1'b0, ptr} + RR_CAND_W'(k);
      if (cand >= RR_CAND_W'(num_req)) cand = cand - RR_CAND_W'(num_req);
      if (k < num_req && !r.found && valid[cand[RR_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = cand[RR_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/div_unsigned.sv
// Restoring unsigned divider, one quotient bit per cycle; single-pulse
// valid_in starts it and a single-pulse valid_out returns the quotient.
module div_unsigned #(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      valid_out,
  output logic [DIVIDEND_WIDTH-1:0] quotient
);

  typedef enum logic {INIT, LOOP} div_state_t;

  localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);

  div_state_t                 state;
  logic [CNT_W-1:0]           count;
  logic [DIVIDEND_WIDTH-1:0]  q_shift;
  logic [DIVISOR_WIDTH-1:0]   rem;
  logic [DIVISOR_WIDTH-1:0]   dvsr;
  logic [DIVISOR_WIDTH:0]     rem_trial;
  logic [DIVISOR_WIDTH-1:0]   rem_next;
  logic                       q_bit;

  // NOTE: every always_comb output gets a value on entry so no path can infer a latch.
  always_comb begin
    rem_trial = {rem, q_shift[DIVIDEND_WIDTH-1]};
    q_bit     = (rem_trial >= {1'b0, dvsr});
    rem_next  = q_bit ? DIVISOR_WIDTH'(rem_trial - {1'b0, dvsr}) : DIVISOR_WIDTH'(rem_trial);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      count     <= '0;
      q_shift   <= '0;
      rem       <= '0;
      dvsr      <= '0;
      valid_out <= 1'b0;
      quotient  <= '0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        INIT: begin
          if (valid_in) begin
            // Divide by one needs no iterations; answer on the next cycle.
            if (divisor == DIVISOR_WIDTH'(1)) begin
              quotient  <= dividend;
              valid_out <= 1'b1;
            end else begin
              q_shift <= dividend;
              dvsr    <= divisor;
              rem     <= '0;
              count   <= '0;
              state   <= LOOP;
            end
          end
        end
        LOOP: begin
          q_shift <= {q_shift[DIVIDEND_WIDTH-2:0], q_bit};
          rem     <= rem_next;
          count   <= count + 1'b1;
          if (count == CNT_W'(DIVIDEND_WIDTH - 1)) begin
            quotient  <= {q_shift[DIVIDEND_WIDTH-2:0], q_bit};
            valid_out <= 1'b1;
            state     <= INIT;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one div_unsigned between NUM_REQ requesters,
// with trivial operands answered directly without the divider.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int DIVIDEND_WIDTH = 16,
  parameter  int DIVISOR_WIDTH  = 8,
  localparam int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]  req_divisor,
  output logic [NUM_REQ-1:0]                resp_valid,
  input  logic [NUM_REQ-1:0]                resp_ready,
  output logic [DIVIDEND_WIDTH-1:0]         resp_quotient,
  output logic [ID_W-1:0]                   resp_id,
  output logic                              resp_dbz,
  output logic                              busy
);

  arb_state_t                 state;
  logic [ID_W-1:0]            rr_ptr;
  rr_pick_t                   pick;
  logic [ID_W-1:0]            grant_id;
  logic                       handshake;
  logic [DIVIDEND_WIDTH-1:0]  sel_dividend;
  logic [DIVISOR_WIDTH-1:0]   sel_divisor;
  logic [DIVIDEND_WIDTH-1:0]  op_dividend;
  logic [DIVISOR_WIDTH-1:0]   op_divisor;
  logic                       div_valid_in;
  logic                       div_valid_out;
  logic [DIVIDEND_WIDTH-1:0]  div_quotient;

  always_comb begin
    pick     = rr_pick(RR_MAX'(req_valid), RR_IDX_W'(rr_ptr), NUM_REQ);
    grant_id = ID_W'(pick.idx);
    // Gated by reset_n so every output reads 0 while reset is held.
    req_ready = '0;
    if (state == IDLE && pick.found && reset_n) req_ready = NUM_REQ'(1) << grant_id;
    handshake = |(req_valid & req_ready);

    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_dividend = req_dividend[i*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
        sel_divisor  = req_divisor[i*DIVISOR_WIDTH +: DIVISOR_WIDTH];
      end
    end
  end

  assign div_valid_in = (state == ISSUE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      op_dividend   <= '0;
      op_divisor    <= '0;
      resp_valid    <= '0;
      resp_quotient <= '0;
      resp_id       <= '0;
      resp_dbz      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            resp_id     <= grant_id;
            op_dividend <= sel_dividend;
            op_divisor  <= sel_divisor;
            rr_ptr      <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            busy        <= 1'b1;
            if (sel_divisor == '0) begin
              resp_quotient <= '1;
              resp_dbz      <= 1'b1;
              resp_valid    <= NUM_REQ'(1) << grant_id;
              state         <= RESP;
            end else if (sel_dividend < DIVIDEND_WIDTH'(sel_divisor)) begin
              // Divisor is non-zero here, so this also covers a zero dividend.
              resp_quotient <= '0;
              resp_dbz      <= 1'b0;
              resp_valid    <= NUM_REQ'(1) << grant_id;
              state         <= RESP;
            end else begin
              resp_dbz <= 1'b0;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (div_valid_out) begin
            resp_quotient <= div_quotient;
            resp_valid    <= NUM_REQ'(1) << resp_id;
            state         <= RESP;
          end
        end
        RESP: begin
          if (resp_ready[resp_id]) begin
            resp_valid <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  div_unsigned #(
    .DIVIDEND_WIDTH(DIVIDEND_WIDTH),
    .DIVISOR_WIDTH (DIVISOR_WIDTH)
  ) u_div (
    .clk      (clk),
    .reset    (~reset_n),
    .valid_in (div_valid_in),
    .dividend (op_dividend),
    .divisor  (op_divisor),
    .valid_out(div_valid_out),
    .quotient (div_quotient)
  );

endmodule
